// File: rtl/qlab5_memarb_pkg.sv
// Shared types for the qlab5 on-chip memory arbiter: FSM states, port ids and small helpers.
package qlab5_memarb_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  typedef logic port_id_t;

  localparam port_id_t P0 = 1'b0;
  localparam port_id_t P1 = 1'b1;

  // A simultaneous read+write request is treated as a write, so it never produces read data.
  function automatic logic is_read(input logic rd, input logic wr);
    return rd & ~wr;
  endfunction

endpackage

// File: rtl/qlab5_rr_arb2.sv
// Two-way round-robin arbiter: grants a lone requester, alternates on conflict, p0 priority after init.
module qlab5_rr_arb2
  import qlab5_memarb_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  port_id_t last_r;

  // Grant decision for the current cycle; only the port not granted last wins a conflict.
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (last_r == P0) ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end else begin
      gnt = 2'b00;
    end
  end

  // Last-granted pointer; parked on p1 while disabled so p0 wins the first conflict.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_r <= P1;
    end else if (!en) begin
      last_r <= P1;
    end else if (gnt[0]) begin
      last_r <= P0;
    end else if (gnt[1]) begin
      last_r <= P1;
    end else begin
      last_r <= last_r;
    end
  end

endmodule

// File: rtl/qlab5_sys_onchip_mem_arbiter.sv
// Two-master Avalon-MM arbiter in front of the single-port on-chip RAM (1-cycle read latency).
// Optional performance counters are built when QLAB5_MEMARB_PERF_CNT_EN is defined.
module qlab5_sys_onchip_mem_arbiter
  import qlab5_memarb_pkg::*;
#(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32,
  parameter int BE_W   = DATA_W / 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] p0_address,
  input  logic [BE_W-1:0]   p0_byteenable,
  input  logic              p0_read,
  input  logic              p0_write,
  input  logic [DATA_W-1:0] p0_writedata,
  output logic              p0_waitrequest,
  output logic [DATA_W-1:0] p0_readdata,
  output logic              p0_readdatavalid,
  input  logic [ADDR_W-1:0] p1_address,
  input  logic [BE_W-1:0]   p1_byteenable,
  input  logic              p1_read,
  input  logic              p1_write,
  input  logic [DATA_W-1:0] p1_writedata,
  output logic              p1_waitrequest,
  output logic [DATA_W-1:0] p1_readdata,
  output logic              p1_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic [CNT_W-1:0]  perf_grant0,
  output logic [CNT_W-1:0]  perf_grant1,
  output logic [CNT_W-1:0]  perf_conflict
);

  state_e     state_r;
  state_e     state_nxt_s;
  logic       run_s;
  logic [1:0] req_s;
  logic [1:0] gnt_s;
  logic       rd_issue_s;
  port_id_t   rd_port_s;
  logic       rsp_valid_r;
  port_id_t   rsp_port_r;

  assign run_s = (state_r == ST_RUN);
  assign req_s = {p1_read | p1_write, p0_read | p0_write};

  qlab5_rr_arb2 u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (run_s),
    .req     (req_s),
    .gnt     (gnt_s)
  );

  // State register: init is held through reset and for one clock after release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_INIT;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_INIT: state_nxt_s = ST_RUN;
      ST_RUN:  state_nxt_s = ST_RUN;
      default: state_nxt_s = ST_INIT;
    endcase
  end

  // Memory-side mux and waitrequests; waitrequest depends only on requests and registered state.
  always_comb begin
    p0_waitrequest = 1'b1;
    p1_waitrequest = 1'b1;
    mem_address    = p0_address;
    mem_byteenable = p0_byteenable;
    mem_writedata  = p0_writedata;
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    mem_clken      = 1'b0;
    rd_issue_s     = 1'b0;
    rd_port_s      = P0;
    if (run_s) begin
      mem_clken      = 1'b1;
      p0_waitrequest = req_s[0] & ~gnt_s[0];
      p1_waitrequest = req_s[1] & ~gnt_s[1];
      if (gnt_s[1]) begin
        mem_address    = p1_address;
        mem_byteenable = p1_byteenable;
        mem_writedata  = p1_writedata;
        mem_chipselect = 1'b1;
        mem_write      = p1_write;
        rd_issue_s     = is_read(p1_read, p1_write);
        rd_port_s      = P1;
      end else if (gnt_s[0]) begin
        mem_chipselect = 1'b1;
        mem_write      = p0_write;
        rd_issue_s     = is_read(p0_read, p0_write);
        rd_port_s      = P0;
      end else begin
        mem_chipselect = 1'b0;
        mem_write      = 1'b0;
      end
    end else begin
      mem_clken = 1'b0;
    end
  end

  // One-entry response pipe matching the RAM's single-cycle read latency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid_r <= 1'b0;
      rsp_port_r  <= P0;
    end else begin
      rsp_valid_r <= rd_issue_s;
      rsp_port_r  <= rd_port_s;
    end
  end

  assign p0_readdatavalid = rsp_valid_r & (rsp_port_r == P0);
  assign p1_readdatavalid = rsp_valid_r & (rsp_port_r == P1);
  assign p0_readdata      = mem_readdata;
  assign p1_readdata      = mem_readdata;

`ifdef QLAB5_MEMARB_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] grant0_r;
  logic [CNT_W-1:0] grant1_r;
  logic [CNT_W-1:0] conflict_r;

  // Saturating grant and conflict counters, cleared only by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant0_r   <= {CNT_W{1'b0}};
      grant1_r   <= {CNT_W{1'b0}};
      conflict_r <= {CNT_W{1'b0}};
    end else begin
      if (gnt_s[0] && (grant0_r != CNT_MAX)) begin
        grant0_r <= grant0_r + CNT_ONE;
      end
      if (gnt_s[1] && (grant1_r != CNT_MAX)) begin
        grant1_r <= grant1_r + CNT_ONE;
      end
      if (run_s && (&req_s) && (conflict_r != CNT_MAX)) begin
        conflict_r <= conflict_r + CNT_ONE;
      end
    end
  end

  assign perf_grant0   = grant0_r;
  assign perf_grant1   = grant1_r;
  assign perf_conflict = conflict_r;
`else
  assign perf_grant0   = {CNT_W{1'b0}};
  assign perf_grant1   = {CNT_W{1'b0}};
  assign perf_conflict = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_qlab5_sys_onchip_mem_arbiter.sv
// Directed self-checking bench for qlab5_sys_onchip_mem_arbiter with a behavioural RAM and read scoreboard.
module tb_qlab5_sys_onchip_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [10:0] p0_address, p1_address;
  logic [3:0]  p0_byteenable, p1_byteenable;
  logic        p0_read, p0_write, p1_read, p1_write;
  logic [31:0] p0_writedata, p1_writedata;
  logic        p0_waitrequest, p1_waitrequest;
  logic [31:0] p0_readdata, p1_readdata;
  logic        p0_readdatavalid, p1_readdatavalid;
  logic [10:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
  logic [15:0] perf_grant0, perf_grant1, perf_conflict;

  int n_assert = 0;
  int n_fail   = 0;
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic obs_w0, obs_w1;

  always #5 clk = ~clk;

  qlab5_sys_onchip_mem_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .p0_address(p0_address), .p0_byteenable(p0_byteenable), .p0_read(p0_read),
    .p0_write(p0_write), .p0_writedata(p0_writedata), .p0_waitrequest(p0_waitrequest),
    .p0_readdata(p0_readdata), .p0_readdatavalid(p0_readdatavalid),
    .p1_address(p1_address), .p1_byteenable(p1_byteenable), .p1_read(p1_read),
    .p1_write(p1_write), .p1_writedata(p1_writedata), .p1_waitrequest(p1_waitrequest),
    .p1_readdata(p1_readdata), .p1_readdatavalid(p1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_chipselect(mem_chipselect),
    .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata),
    .perf_grant0(perf_grant0), .perf_grant1(perf_grant1), .perf_conflict(perf_conflict)
  );

  // RAM model: unwritten words hold a fixed address-derived pattern.
  logic [31:0]   ram [0:2047];
  logic [2047:0] ram_wr = '0;
  logic [31:0]   ram_q = 32'h0;

  function automatic logic [31:0] init_val(input logic [10:0] a);
    return {5'b10100, a, 5'b01011, a};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    if (mem_clken && mem_chipselect) begin
      if (mem_write) begin
        ram[mem_address]    <= merge(ram_wr[mem_address] ? ram[mem_address] : init_val(mem_address),
                                     mem_writedata, mem_byteenable);
        ram_wr[mem_address] <= 1'b1;
      end else begin
        ram_q <= ram_wr[mem_address] ? ram[mem_address] : init_val(mem_address);
      end
    end
  end
  assign mem_readdata = ram_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int p);
    if (p == 0) begin
      p0_read = 1'b0; p0_write = 1'b0; p0_address = 11'h0; p0_byteenable = 4'h0; p0_writedata = 32'h0;
    end else begin
      p1_read = 1'b0; p1_write = 1'b0; p1_address = 11'h0; p1_byteenable = 4'h0; p1_writedata = 32'h0;
    end
  endtask

  task automatic wr(input int p, input logic [10:0] a, input logic [3:0] be, input logic [31:0] d);
    if (p == 0) begin
      p0_read = 1'b0; p0_write = 1'b1; p0_address = a; p0_byteenable = be; p0_writedata = d;
    end else begin
      p1_read = 1'b0; p1_write = 1'b1; p1_address = a; p1_byteenable = be; p1_writedata = d;
    end
  endtask

  task automatic rd(input int p, input logic [10:0] a, input logic [31:0] exp);
    if (p == 0) begin
      p0_read = 1'b1; p0_write = 1'b0; p0_address = a; p0_byteenable = 4'hF; p0_writedata = 32'h0;
      q0.push_back(exp);
    end else begin
      p1_read = 1'b1; p1_write = 1'b0; p1_address = a; p1_byteenable = 4'hF; p1_writedata = 32'h0;
      q1.push_back(exp);
    end
  endtask

  // One run-mode cycle: inputs were set at posedge+1, outputs are sampled at the negedge.
  task automatic cyc(input logic ew0, input logic ew1, input logic ecs, input logic ev0, input logic ev1);
    @(negedge clk);
    obs_w0 = p0_waitrequest;
    obs_w1 = p1_waitrequest;
    chk("p0_waitrequest", 32'(p0_waitrequest), 32'(ew0));
    chk("p1_waitrequest", 32'(p1_waitrequest), 32'(ew1));
    chk("mem_chipselect", 32'(mem_chipselect), 32'(ecs));
    chk("mem_clken", 32'(mem_clken), 32'd1);
    chk("p0_readdatavalid", 32'(p0_readdatavalid), 32'(ev0));
    chk("p1_readdatavalid", 32'(p1_readdatavalid), 32'(ev1));
    if (p0_readdatavalid && q0.size() > 0) chk("p0_readdata", p0_readdata, q0.pop_front());
    if (p1_readdatavalid && q1.size() > 0) chk("p1_readdata", p1_readdata, q1.pop_front());
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle(0); idle(1);
    reset_n = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("rst_p0_waitrequest", 32'(p0_waitrequest), 32'd1);
      chk("rst_p1_waitrequest", 32'(p1_waitrequest), 32'd1);
      chk("rst_mem_clken", 32'(mem_clken), 32'd0);
      chk("rst_mem_chipselect", 32'(mem_chipselect), 32'd0);
      chk("rst_valids", {30'b0, p1_readdatavalid, p0_readdatavalid}, 32'd0);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("init_p0_waitrequest", 32'(p0_waitrequest), 32'd1);
    chk("init_p1_waitrequest", 32'(p1_waitrequest), 32'd1);
    chk("init_mem_clken", 32'(mem_clken), 32'd0);
    chk("init_valids", {30'b0, p1_readdatavalid, p0_readdatavalid}, 32'd0);
    @(posedge clk); #1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int n0, n1;
    logic [10:0] a0, a1;
    logic g;

    // Reset and release.
    do_reset();

    // Write then read-back through the other port.
    wr(0, 11'h005, 4'hF, 32'hDEADBEEF);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(0); rd(1, 11'h005, 32'hDEADBEEF);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Conflict with p0 granted last: p1 first, p0 stalled once.
    wr(1, 11'h020, 4'hF, 32'h20202020);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(1); wr(0, 11'h010, 4'hF, 32'h10101010);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    rd(0, 11'h010, 32'h10101010); rd(1, 11'h020, 32'h20202020);
    @(negedge clk);
    chk("conflict_mem_address", 32'(mem_address), 32'h020);
    @(posedge clk); #1;
    n_assert = n_assert;
    // Above cycle consumed the first conflict cycle; re-check its effect via the p1 valid next.
    idle(1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    idle(0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Byte-enable merge at the top address.
    wr(0, 11'h7FF, 4'hF, 32'h11223344);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    wr(0, 11'h7FF, 4'b0010, 32'h0000AB00);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    rd(0, 11'h7FF, 32'h1122AB44);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Streaming conflict: 100 cycles, strict alternation starting with p0 after reset.
    do_reset();
    rd(0, 11'h100, init_val(11'h100)); rd(1, 11'h200, init_val(11'h200));
    a0 = 11'h101; a1 = 11'h201; n0 = 0; n1 = 0;
    for (int k = 0; k < 100; k++) begin
      g = k[0];
      cyc(g, ~g, 1'b1, k[0], (k > 0) && !k[0]);
      if (!obs_w0) n0++;
      if (!obs_w1) n1++;
      if (!g) begin
        rd(0, a0, init_val(a0)); a0 = a0 + 11'd1;
      end else if (k != 99) begin
        rd(1, a1, init_val(a1)); a1 = a1 + 11'd1;
      end else begin
        idle(1);
      end
    end
    chk("stream_p0_grants", 32'(n0), 32'd50);
    chk("stream_p1_grants", 32'(n1), 32'd50);
`ifdef QLAB5_MEMARB_PERF_CNT_EN
    chk("perf_grant0", 32'(perf_grant0), 32'd50);
    chk("perf_grant1", 32'(perf_grant1), 32'd50);
    chk("perf_conflict", 32'(perf_conflict), 32'd100);
`else
    chk("perf_grant0", 32'(perf_grant0), 32'd0);
    chk("perf_grant1", 32'(perf_grant1), 32'd0);
    chk("perf_conflict", 32'(perf_conflict), 32'd0);
`endif
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    idle(0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Reset hits while a read is granted: no late valid, pointer back to p0.
    p0_read = 1'b1; p0_address = 11'h005; p0_byteenable = 4'hF;
    @(negedge clk);
    chk("pre_reset_grant", {30'b0, mem_chipselect, p0_waitrequest}, 32'd2);
    #2;
    reset_n = 1'b0;
    do_reset();
    rd(0, 11'h005, 32'hDEADBEEF); rd(1, 11'h7FF, 32'h1122AB44);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("scoreboard_empty", 32'(q0.size() + q1.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
